// File: rtl/uart_rx_loader.sv
// UART receiver that assembles 3-byte load frames (header 0xA0-0xA3, data hi, data lo).
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        uart_en,
    output logic [1:0]  uart_sel,
    output logic [15:0] uart_data,
    output logic        rx_err
);

    localparam int CW             = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_BIT      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_TICK     = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

    rx_state_t       state;
    rx_state_t       next_state;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            tick;
    logic            byte_ok;
    logic            byte_bad;
    logic [1:0]      byte_idx;
    logic [1:0]      sel_hold;
    logic [7:0]      data_hi;
    logic [TW-1:0]   idle_timer;
    logic            timeout;

    // rx_prev trails the synchronizer by one cycle so a falling edge can be seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick = (bit_cnt == LAST_TICK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    next_state = START;
                end
            end
            START: begin
                if (bit_cnt == HALF_BIT) begin
                    next_state = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The bit counter restarts on every state change so each sample lands at bit centre.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE || next_state != state || tick) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (state == DATA && tick) begin
                bit_idx   <= bit_idx + 1'b1;
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_err <= 1'b0;
        end else if (state == IDLE) begin
            par_err <= 1'b0;
        end else if (state == PARITY && tick) begin
            par_err <= (^shift_reg) ^ rx_sync;
        end
    end
`endif

    always_comb begin
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (state == STOP && tick) begin
`ifdef UART_RX_PARITY_EN
            if (rx_sync && !par_err) begin
`else
            if (rx_sync) begin
`endif
                byte_ok = 1'b1;
            end else begin
                byte_bad = 1'b1;
            end
        end
    end

    // Inter-byte gap timer only runs while a partial frame is waiting in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_timer <= '0;
        end else if (byte_idx == 2'd0 || state != IDLE) begin
            idle_timer <= '0;
        end else if (!timeout) begin
            idle_timer <= idle_timer + 1'b1;
        end
    end

    assign timeout = (byte_idx != 2'd0) && (idle_timer == TIMEOUT_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx  <= 2'd0;
            sel_hold  <= 2'b00;
            data_hi   <= 8'h00;
            uart_en   <= 1'b0;
            uart_sel  <= 2'b00;
            uart_data <= 16'h0000;
            rx_err    <= 1'b0;
        end else begin
            uart_en <= 1'b0;
            rx_err  <= 1'b0;
            if (byte_bad || timeout) begin
                byte_idx <= 2'd0;
                rx_err   <= 1'b1;
            end else if (byte_ok) begin
                case (byte_idx)
                    2'd0: begin
                        if (shift_reg[7:2] == 6'b101000) begin
                            sel_hold <= shift_reg[1:0];
                            byte_idx <= 2'd1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        data_hi  <= shift_reg;
                        byte_idx <= 2'd2;
                    end
                    2'd2: begin
                        uart_sel  <= sel_hold;
                        uart_data <= {data_hi, shift_reg};
                        uart_en   <= 1'b1;
                        byte_idx  <= 2'd0;
                    end
                    default: byte_idx <= 2'd0;
                endcase
            end
        end
    end

endmodule
